// File: rtl/axi_stream_writer_pkg.sv
// axi_stream_writer_pkg
//   Shared types and helpers for the AXI stream writer.
//   - state_e         : writer FSM states
//   - BoundaryBits    : AXI bursts may not cross a (1 << BoundaryBits) byte page
//   - axi_*_t         : default AXI4 channel, request and response structs
//   - calcBurstBeats  : beats for the next burst (remaining / max / page limit)
package axi_stream_writer_pkg;

  // 4 KiB page: a burst must stay inside one page
  localparam int unsigned BoundaryBits = 12;
  localparam logic [BoundaryBits:0] BoundaryBytes = {1'b1, {BoundaryBits{1'b0}}};

  // Widths of the default AXI structs; a custom req_t/rsp_t must match the
  // writer's AddrWidth/DataWidth/IdWidth/UserWidth parameters
  localparam int unsigned PkgAddrWidth = 32;
  localparam int unsigned PkgDataWidth = 64;
  localparam int unsigned PkgIdWidth   = 1;
  localparam int unsigned PkgUserWidth = 1;

  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StAw,
    StW,
    StB
  } state_e;

  // AW and AR share the same layout
  typedef struct packed {
    logic [PkgIdWidth-1:0]   id;
    logic [PkgAddrWidth-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic                    lock;
    logic [3:0]              cache;
    logic [2:0]              prot;
    logic [3:0]              qos;
    logic [3:0]              region;
    logic [PkgUserWidth-1:0] user;
  } axi_ax_chan_t;

  typedef struct packed {
    logic [PkgDataWidth-1:0]   data;
    logic [PkgDataWidth/8-1:0] strb;
    logic                      last;
    logic [PkgUserWidth-1:0]   user;
  } axi_w_chan_t;

  typedef struct packed {
    logic [PkgIdWidth-1:0]   id;
    logic [1:0]              resp;
    logic [PkgUserWidth-1:0] user;
  } axi_b_chan_t;

  typedef struct packed {
    logic [PkgIdWidth-1:0]   id;
    logic [PkgDataWidth-1:0] data;
    logic [1:0]              resp;
    logic                    last;
    logic [PkgUserWidth-1:0] user;
  } axi_r_chan_t;

  typedef struct packed {
    axi_ax_chan_t aw;
    logic         aw_valid;
    axi_w_chan_t  w;
    logic         w_valid;
    logic         b_ready;
    axi_ax_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } axi_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    logic        b_valid;
    axi_b_chan_t b;
    logic        r_valid;
    axi_r_chan_t r;
  } axi_rsp_t;

  // Beats of the next burst: the smallest of what is left to send, the
  // configured maximum and the beats that still fit before the page end.
  // addrLow is beat-aligned, so at least one beat always fits.
  function automatic logic [8:0] calcBurstBeats(
    input logic [31:0]             remaining,
    input logic [BoundaryBits-1:0] addrLow,
    input int unsigned             sizeLog2,
    input int unsigned             maxBurst
  );
    logic [BoundaryBits:0] bytesLeft;
    logic [31:0]           toBoundary;
    logic [31:0]           beats;
    bytesLeft  = BoundaryBytes - {1'b0, addrLow};
    toBoundary = 32'(bytesLeft) >> sizeLog2;
    beats      = remaining;
    if (beats > maxBurst) begin
      beats = maxBurst;
    end
    if (beats > toBoundary) begin
      beats = toBoundary;
    end
    return beats[8:0];
  endfunction

endpackage

// File: rtl/axi_stream_writer_if.sv
// axi_stream_writer_if
//   Bundles one AXI4 master request/response pair.
//   - req : request struct (AW/W/B-ready/AR/R-ready), driven by the master
//   - rsp : response struct (ready signals, B, R), driven by the slave
//   Modports: master (drives req), slave (drives rsp).
interface axi_stream_writer_if
  import axi_stream_writer_pkg::*;
();

  axi_req_t req;
  axi_rsp_t rsp;

  modport master (output req, input rsp);
  modport slave  (input req, output rsp);

endinterface

// File: rtl/axi_stream_writer.sv
// axi_stream_writer
//   Writes a beat stream into memory as a sequence of AXI4 INCR bursts,
//   one burst outstanding at a time, never crossing a 4 KiB page.
//
// Ports
//   clk_i, rst_i   : clock, synchronous active-high reset
//   start_i        : command strobe (accepted only when idle)
//   addr_i         : start byte address (low bits cleared to beat alignment)
//   num_beats_i    : number of data beats (0 completes at once)
//   data_i, data_valid_i, data_ready_o : incoming data stream
//   busy_o, done_o, err_o : status (done_o is a one-cycle pulse)
//   axi_req_o, axi_rsp_i  : AXI4 master request / response
//
// Configuration
//   AXI_STREAM_WRITER_BRESP_CHECK_EN : when defined, a non-OKAY B response sets
//   err_o (sticky until the next accepted start_i). Otherwise err_o is 0.
module axi_stream_writer
  import axi_stream_writer_pkg::*;
#(
  parameter int unsigned        AddrWidth   = 32,
  parameter int unsigned        DataWidth   = 64,
  parameter int unsigned        IdWidth     = 1,
  parameter int unsigned        UserWidth   = 1,
  parameter type                req_t       = axi_req_t,
  parameter type                rsp_t       = axi_rsp_t,
  parameter int unsigned        MaxBurstLen = 16,
  parameter logic [IdWidth-1:0] AxiId       = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [31:0]          num_beats_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 data_valid_i,
  output logic                 data_ready_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output req_t                 axi_req_o,
  input  rsp_t                 axi_rsp_i
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned SizeLog2  = $clog2(StrbWidth);
  localparam logic [AddrWidth-1:0] AlignMask = ~AddrWidth'(StrbWidth - 1);

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [31:0]          remaining_q, remaining_d;
  logic [8:0]           burstLen_q, burstLen_d;
  logic [8:0]           beatCnt_q, beatCnt_d;
  logic                 done_q, done_d;

  logic [8:0] curBeats;
  logic       wLast;

  // Only the B channel of the response is used; AR/R are never issued
  logic unused_rsp;
  assign unused_rsp = ^axi_rsp_i;

`ifdef AXI_STREAM_WRITER_BRESP_CHECK_EN
  logic err_q, err_d;
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign busy_o = (state_q != StIdle);
  assign done_o = done_q;

  // Burst size is derived from the registered address and remaining count,
  // so AW fields stay stable for as long as the FSM waits in AW.
  assign curBeats = calcBurstBeats(remaining_q, addr_q[BoundaryBits-1:0],
                                   SizeLog2, MaxBurstLen);
  assign wLast    = (beatCnt_q == burstLen_q - 9'd1);

  // Next-state and output logic. Every AXI field defaults to zero, so AR,
  // R-ready and unused AW/W fields are held low without further effort.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    burstLen_d   = burstLen_q;
    beatCnt_d    = beatCnt_q;
    done_d       = 1'b0;
`ifdef AXI_STREAM_WRITER_BRESP_CHECK_EN
    err_d        = err_q;
`endif
    axi_req_o    = '0;
    data_ready_o = 1'b0;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          addr_d      = addr_i & AlignMask;
          remaining_d = num_beats_i;
`ifdef AXI_STREAM_WRITER_BRESP_CHECK_EN
          err_d       = 1'b0;
`endif
          // An empty command completes immediately with no AXI traffic
          if (num_beats_i == 32'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = StAw;
          end
        end
      end

      StAw: begin
        axi_req_o.aw_valid = 1'b1;
        axi_req_o.aw.id    = AxiId;
        axi_req_o.aw.addr  = addr_q;
        axi_req_o.aw.len   = 8'(curBeats - 9'd1);
        axi_req_o.aw.size  = 3'(SizeLog2);
        axi_req_o.aw.burst = BurstIncr;
        if (axi_rsp_i.aw_ready) begin
          burstLen_d = curBeats;
          beatCnt_d  = 9'd0;
          state_d    = StW;
        end
      end

      StW: begin
        // Stream and W channel are wired straight through while in W
        axi_req_o.w_valid = data_valid_i;
        axi_req_o.w.data  = data_i;
        axi_req_o.w.strb  = '1;
        axi_req_o.w.last  = wLast;
        data_ready_o      = axi_rsp_i.w_ready;
        if (data_valid_i && axi_rsp_i.w_ready) begin
          beatCnt_d = beatCnt_q + 9'd1;
          if (wLast) begin
            state_d = StB;
          end
        end
      end

      StB: begin
        axi_req_o.b_ready = 1'b1;
        if (axi_rsp_i.b_valid) begin
          // Address arithmetic wraps naturally at AddrWidth bits
          addr_d      = addr_q + (AddrWidth'(burstLen_q) << SizeLog2);
          remaining_d = remaining_q - 32'(burstLen_q);
`ifdef AXI_STREAM_WRITER_BRESP_CHECK_EN
          if (axi_rsp_i.b.resp != RespOkay) begin
            err_d = 1'b1;
          end
`endif
          if (remaining_q == 32'(burstLen_q)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StAw;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset abandons any transfer in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      burstLen_q  <= '0;
      beatCnt_q   <= '0;
      done_q      <= 1'b0;
`ifdef AXI_STREAM_WRITER_BRESP_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      burstLen_q  <= burstLen_d;
      beatCnt_q   <= beatCnt_d;
      done_q      <= done_d;
`ifdef AXI_STREAM_WRITER_BRESP_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_axi_stream_writer.sv
// tb_axi_stream_writer
//   Self-checking bench for axi_stream_writer with DataWidth=64, MaxBurstLen=16.
//   A behavioural AXI slave stores W beats into a sparse memory and logs AWs;
//   a stream producer feeds a known data pattern. Directed transfers come from
//   a vector table; reset, zero-length, busy-start and B-error cases are
//   written out by hand.
module tb_axi_stream_writer;
  import axi_stream_writer_pkg::*;

`ifdef AXI_STREAM_WRITER_BRESP_CHECK_EN
  localparam logic ExpErr = 1'b1;
`else
  localparam logic ExpErr = 1'b0;
`endif

  localparam int NumVecs = 6;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] num_beats_i = '0;
  logic [63:0] data_i = '0;
  logic        data_valid_i = 1'b0;
  logic        data_ready_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  axi_stream_writer_if axiBus ();

  axi_req_t mstReq;
  axi_rsp_t slvRsp = '0;
  assign mstReq     = axiBus.req;
  assign axiBus.rsp = slvRsp;

  axi_stream_writer #(
    .AddrWidth  (32),
    .DataWidth  (64),
    .IdWidth    (1),
    .UserWidth  (1),
    .MaxBurstLen(16),
    .AxiId      (1'b0)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .addr_i      (addr_i),
    .num_beats_i (num_beats_i),
    .data_i      (data_i),
    .data_valid_i(data_valid_i),
    .data_ready_o(data_ready_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .axi_req_o   (axiBus.req),
    .axi_rsp_i   (axiBus.rsp)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Slave and producer knobs, set by the test sequences
  int          awStall = 0;
  bit          wGaps = 1'b0;
  bit          streamGaps = 1'b0;
  int          errAtB = -1;

  // Slave and monitor state
  int          stallCnt = 0;
  bit          awActive = 1'b0;
  bit          awWaitPrev = 1'b0;
  axi_ax_chan_t awPrev;
  logic [31:0] curAddr = '0;
  int          curLen = 0;
  int          beatIdx = 0;
  bit          bPend = 1'b0;
  logic [1:0]  bResp = RespOkay;
  int          bCount = 0;
  int          arViolations = 0;
  int          doneCount = 0;
  int          awValidSeen = 0;
  int unsigned streamCnt = 0;
  logic [31:0] awAddrLog[$];
  int          awLenLog[$];
  logic [63:0] mem[logic [31:0]];

  typedef struct {
    logic [31:0] addr;
    int          beats;
    int          stall;
    bit          gaps;
    int          nBursts;
    logic [31:0] expAddr[3];
    int          expLen[3];
  } vec_t;

  vec_t vecs[NumVecs];

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [63:0] pattern(input int unsigned idx);
    return {idx ^ 32'hA5A5_5A5A, ~idx};
  endfunction

  // Stream producer: advances the pattern on every accepted beat
  always @(posedge clk_i) begin
    if (data_valid_i && data_ready_o) begin
      streamCnt++;
    end
    #1;
    data_i       = pattern(streamCnt);
    data_valid_i = streamGaps ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Behavioural AXI slave: logs AWs, checks AW stability and W framing,
  // stores beats into memory and answers each burst with one B
  always @(posedge clk_i) begin
    if (rst_i) begin
      awActive   = 1'b0;
      awWaitPrev = 1'b0;
      bPend      = 1'b0;
      stallCnt   = 0;
    end else begin
      if (mstReq.ar_valid || mstReq.r_ready) begin
        arViolations++;
      end
      if (awWaitPrev) begin
        checkOutput("aw_hold_valid", 64'(mstReq.aw_valid), 64'(1'b1));
        checkOutput("aw_hold_fields", 64'(mstReq.aw), 64'(awPrev));
      end
      awWaitPrev = 1'b0;
      if (slvRsp.b_valid && mstReq.b_ready) begin
        bCount++;
        bPend = 1'b0;
      end
      if (mstReq.aw_valid && slvRsp.aw_ready) begin
        awAddrLog.push_back(mstReq.aw.addr);
        awLenLog.push_back(int'(mstReq.aw.len));
        checkOutput("aw_size", 64'(mstReq.aw.size), 64'(3));
        checkOutput("aw_burst", 64'(mstReq.aw.burst), 64'(BurstIncr));
        checkOutput("aw_other", 64'({mstReq.aw.id, mstReq.aw.lock, mstReq.aw.cache,
                    mstReq.aw.prot, mstReq.aw.qos, mstReq.aw.region, mstReq.aw.user}), 64'(0));
        checkOutput("aw_4k", 64'((32'(mstReq.aw.addr[11:0]) + (32'(mstReq.aw.len) + 1) * 8) <= 4096),
                    64'(1));
        curAddr  = mstReq.aw.addr;
        curLen   = int'(mstReq.aw.len);
        beatIdx  = 0;
        awActive = 1'b1;
        stallCnt = 0;
      end else if (mstReq.aw_valid) begin
        stallCnt++;
        awWaitPrev = 1'b1;
        awPrev     = mstReq.aw;
      end
      if (mstReq.w_valid && slvRsp.w_ready) begin
        checkOutput("w_in_burst", 64'(awActive), 64'(1'b1));
        checkOutput("w_last", 64'(mstReq.w.last), 64'(beatIdx == curLen));
        checkOutput("w_strb", 64'(mstReq.w.strb), 64'(8'hFF));
        mem[curAddr + 32'(beatIdx * 8)] = mstReq.w.data;
        if (beatIdx == curLen) begin
          awActive = 1'b0;
          bPend    = 1'b1;
          bResp    = (bCount == errAtB) ? RespSlvErr : RespOkay;
        end
        beatIdx++;
      end
    end
    #1;
    slvRsp.aw_ready = (stallCnt >= awStall);
    slvRsp.w_ready  = wGaps ? 1'($urandom_range(0, 1)) : 1'b1;
    slvRsp.b_valid  = bPend;
    slvRsp.b.resp   = bResp;
  end

  // Done pulses and stray AW activity are counted away from the clock edge
  always @(negedge clk_i) begin
    if (done_o) doneCount++;
    if (mstReq.aw_valid) awValidSeen++;
  end

  task automatic setVec(input int idx, input logic [31:0] addr, input int beats,
                        input int stall, input bit gaps, input int n,
                        input logic [31:0] a0, input int l0, input logic [31:0] a1,
                        input int l1, input logic [31:0] a2, input int l2);
    vecs[idx].addr       = addr;
    vecs[idx].beats      = beats;
    vecs[idx].stall      = stall;
    vecs[idx].gaps       = gaps;
    vecs[idx].nBursts    = n;
    vecs[idx].expAddr[0] = a0;
    vecs[idx].expAddr[1] = a1;
    vecs[idx].expAddr[2] = a2;
    vecs[idx].expLen[0]  = l0;
    vecs[idx].expLen[1]  = l1;
    vecs[idx].expLen[2]  = l2;
  endtask

  task automatic setSlave(input int stall, input bit gaps);
    awStall    = stall;
    wGaps      = gaps;
    streamGaps = gaps;
  endtask

  // Bounded wait at negedges for a counter to reach a target
  // (0 = B responses, 1 = done pulses, 2 = AW handshakes, 3 = stream beats)
  task automatic waitFor(input int which, input int target, input string tag);
    int cur;
    for (int i = 0; i < 4000; i++) begin
      case (which)
        0:       cur = bCount;
        1:       cur = doneCount;
        2:       cur = awAddrLog.size();
        default: cur = int'(streamCnt);
      endcase
      if (cur >= target) return;
      @(negedge clk_i);
    end
    checkOutput({tag, "_timeout"}, 64'(cur), 64'(target));
  endtask

  task automatic doStart(input logic [31:0] addr, input logic [31:0] beats);
    @(negedge clk_i);
    start_i     = 1'b1;
    addr_i      = addr;
    num_beats_i = beats;
    @(negedge clk_i);
    start_i     = 1'b0;
  endtask

  task automatic checkAllIdle(input string tag);
    checkOutput({tag, "_aw_valid"}, 64'(mstReq.aw_valid), 64'(0));
    checkOutput({tag, "_w_valid"}, 64'(mstReq.w_valid), 64'(0));
    checkOutput({tag, "_b_ready"}, 64'(mstReq.b_ready), 64'(0));
    checkOutput({tag, "_data_ready"}, 64'(data_ready_o), 64'(0));
    checkOutput({tag, "_busy"}, 64'(busy_o), 64'(0));
    checkOutput({tag, "_done"}, 64'(done_o), 64'(0));
    checkOutput({tag, "_err"}, 64'(err_o), 64'(0));
  endtask

  // Checks the memory image of the last transfer against the stream pattern
  task automatic checkMemory(input string tag, input logic [31:0] base,
                             input int beats, input int unsigned streamBase);
    logic [31:0] a;
    for (int i = 0; i < beats; i++) begin
      a = base + 32'(i * 8);
      checkOutput($sformatf("%s_mem%0d", tag, i), mem.exists(a) ? mem[a] : 64'hDEAD_0000_DEAD_0000,
                  pattern(streamBase + i));
    end
  endtask

  // Runs one table vector: start, wait for done, check AW list, memory,
  // single done pulse and return to idle
  task automatic applyStimulus(input vec_t v, input string tag);
    int          awBase;
    int          doneBase;
    int unsigned streamBase;
    setSlave(v.stall, v.gaps);
    @(negedge clk_i);
    awBase     = awAddrLog.size();
    doneBase   = doneCount;
    streamBase = streamCnt;
    doStart(v.addr, 32'(v.beats));
    waitFor(1, doneBase + 1, tag);
    @(negedge clk_i);
    @(negedge clk_i);
    checkOutput({tag, "_aw_count"}, 64'(awAddrLog.size() - awBase), 64'(v.nBursts));
    for (int i = 0; i < v.nBursts; i++) begin
      if (awBase + i < awAddrLog.size()) begin
        checkOutput($sformatf("%s_aw%0d_addr", tag, i), 64'(awAddrLog[awBase + i]),
                    64'(v.expAddr[i]));
        checkOutput($sformatf("%s_aw%0d_len", tag, i), 64'(awLenLog[awBase + i]),
                    64'(v.expLen[i]));
      end
    end
    checkMemory(tag, v.addr & 32'hFFFF_FFF8, v.beats, streamBase);
    checkOutput({tag, "_done_pulses"}, 64'(doneCount - doneBase), 64'(1));
    checkOutput({tag, "_busy_after"}, 64'(busy_o), 64'(0));
  endtask

  // Watchdog: the run must never hang
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int doneBase;
    int awBase;
    int awSeenBase;
    int bBase;
    int unsigned streamBase;

    //      idx addr          beats stall gaps n   aw0          len  aw1          len  aw2          len
    setVec(0, 32'h0000_1000, 40, 0, 1'b0, 3, 32'h0000_1000, 15, 32'h0000_1080, 15, 32'h0000_1100, 7);
    setVec(1, 32'h0000_0FF0,  8, 0, 1'b0, 2, 32'h0000_0FF0,  1, 32'h0000_1000,  5, 32'h0,         0);
    setVec(2, 32'h0000_2000, 20, 5, 1'b1, 2, 32'h0000_2000, 15, 32'h0000_2080,  3, 32'h0,         0);
    setVec(3, 32'h0000_3007,  3, 0, 1'b0, 1, 32'h0000_3000,  2, 32'h0,          0, 32'h0,         0);
    setVec(4, 32'hFFFF_FFF8,  2, 0, 1'b0, 2, 32'hFFFF_FFF8,  0, 32'h0000_0000,  0, 32'h0,         0);
    setVec(5, 32'h0000_5F88, 17, 5, 1'b1, 2, 32'h0000_5F88, 14, 32'h0000_6000,  1, 32'h0,         0);

    $display("[TB] reset");
    repeat (3) @(negedge clk_i);
    checkAllIdle("reset");
    rst_i = 1'b0;
    @(negedge clk_i);

    $display("[TB] table vectors");
    for (int i = 0; i < NumVecs; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    $display("[TB] zero-length command");
    setSlave(0, 1'b0);
    @(negedge clk_i);
    doneBase   = doneCount;
    awSeenBase = awValidSeen;
    doStart(32'h0000_8000, 32'd0);
    checkOutput("zero_done_next", 64'(done_o), 64'(1));
    checkOutput("zero_busy", 64'(busy_o), 64'(0));
    @(negedge clk_i);
    checkOutput("zero_done_drop", 64'(done_o), 64'(0));
    repeat (4) @(negedge clk_i);
    checkOutput("zero_done_pulses", 64'(doneCount - doneBase), 64'(1));
    checkOutput("zero_no_aw", 64'(awValidSeen - awSeenBase), 64'(0));

    $display("[TB] start while busy");
    @(negedge clk_i);
    doneBase   = doneCount;
    awBase     = awAddrLog.size();
    streamBase = streamCnt;
    doStart(32'h0000_4000, 32'd10);
    waitFor(2, awBase + 1, "busy_aw");
    start_i     = 1'b1;
    addr_i      = 32'h0000_9000;
    num_beats_i = 32'd5;
    @(negedge clk_i);
    start_i     = 1'b0;
    waitFor(1, doneBase + 1, "busy_done");
    repeat (20) @(negedge clk_i);
    checkOutput("busy_aw_count", 64'(awAddrLog.size() - awBase), 64'(1));
    checkOutput("busy_aw_addr", 64'(awAddrLog[awBase]), 64'(32'h0000_4000));
    checkOutput("busy_aw_len", 64'(awLenLog[awBase]), 64'(9));
    checkOutput("busy_done_pulses", 64'(doneCount - doneBase), 64'(1));
    checkOutput("busy_idle_after", 64'(busy_o), 64'(0));
    checkMemory("busy", 32'h0000_4000, 10, streamBase);

    $display("[TB] reset in the middle of W");
    @(negedge clk_i);
    doneBase   = doneCount;
    awBase     = awAddrLog.size();
    streamBase = streamCnt;
    doStart(32'h0000_7000, 32'd32);
    waitFor(2, awBase + 1, "rst_aw");
    waitFor(3, int'(streamBase) + 3, "rst_beats");
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    checkAllIdle("rst_midw");
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checkOutput("rst_no_done", 64'(doneCount - doneBase), 64'(0));
    checkOutput("rst_busy", 64'(busy_o), 64'(0));
    applyStimulus(vecs[3], "after_rst");

    $display("[TB] B error response");
    setSlave(0, 1'b0);
    @(negedge clk_i);
    doneBase = doneCount;
    bBase    = bCount;
    errAtB   = bBase + 1;
    doStart(32'h0000_1000, 32'd40);
    waitFor(0, bBase + 1, "err_b1");
    checkOutput("err_after_b1", 64'(err_o), 64'(0));
    waitFor(0, bBase + 2, "err_b2");
    checkOutput("err_after_b2", 64'(err_o), 64'(ExpErr));
    waitFor(1, doneBase + 1, "err_done");
    checkOutput("err_at_done", 64'(err_o), 64'(ExpErr));
    checkOutput("err_bursts", 64'(bCount - bBase), 64'(3));
    errAtB = -1;
    repeat (2) @(negedge clk_i);
    checkOutput("err_sticky", 64'(err_o), 64'(ExpErr));
    checkOutput("err_done_pulses", 64'(doneCount - doneBase), 64'(1));
    doStart(32'h0000_8000, 32'd0);
    checkOutput("err_cleared", 64'(err_o), 64'(0));

    checkOutput("ar_r_idle", 64'(arViolations), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
